// File: rtl/ajcrisc_pkg.sv
// Shared encodings for the AJC RISC memory path: arbiter state, bus owner codes
// and the read/write convention used by the control unit.
package ajcrisc_pkg;

   typedef enum logic [1:0] {
      S_IDLE  = 2'b00,
      S_ISSUE = 2'b01,
      S_DONE  = 2'b10
   } state_t;

   localparam logic [1:0] OWN_NONE = 2'b00;
   localparam logic [1:0] OWN_CPU  = 2'b01;
   localparam logic [1:0] OWN_DMA  = 2'b10;

   localparam logic RW_READ  = 1'b0;
   localparam logic RW_WRITE = 1'b1;

   function automatic logic [1:0] owner_code(input logic is_dma);
      return is_dma ? OWN_DMA : OWN_CPU;
   endfunction

endpackage

// File: rtl/ajcrisc_starve_cnt.sv
// Saturating count of CPU wins taken while DMA was waiting; at_lim hands the
// next contested arbitration to DMA.
module ajcrisc_starve_cnt #(
   parameter int LIM = 3
) (
   input  logic clk,
   input  logic rst,
   input  logic inc,
   input  logic clr,
   output logic at_lim
);

   logic [3:0] cnt;

   assign at_lim = (cnt == 4'(LIM));

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         cnt <= '0;
      else if (clr)
         cnt <= '0;
      else if (inc && !at_lim)
         cnt <= cnt + 4'd1;
   end

endmodule

// File: rtl/ajcrisc_mem_arb.sv
// CPU / DMA arbiter for the single-port memory: every access is IDLE -> ISSUE -> DONE
// with a one-cycle ack in DONE. CPU wins by default, DMA wins after STARVE_LIM losses.
module ajcrisc_mem_arb
   import ajcrisc_pkg::*;
#(
   parameter int AW         = 8,
   parameter int DW         = 8,
   parameter int STARVE_LIM = 3
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          cpu_req,
   input  logic          cpu_rw,
   input  logic [AW-1:0] cpu_addr,
   input  logic [DW-1:0] cpu_wdata,
   output logic [DW-1:0] cpu_rdata,
   output logic          cpu_ack,
   input  logic          dma_req,
   input  logic          dma_rw,
   input  logic [AW-1:0] dma_addr,
   input  logic [DW-1:0] dma_wdata,
   output logic [DW-1:0] dma_rdata,
   output logic          dma_ack,
   output logic [AW-1:0] mem_addr,
   output logic [DW-1:0] mem_wdata,
   output logic          mem_we,
   input  logic [DW-1:0] mem_rdata,
   output logic [1:0]    owner,
   output logic          busy
);

   state_t state;
   logic   at_lim;
   logic   grant_cpu, grant_dma;

   always_comb begin
      grant_cpu = 1'b0;
      grant_dma = 1'b0;
      if (state == S_IDLE) begin
         if (cpu_req && !(dma_req && at_lim))
            grant_cpu = 1'b1;
         else if (dma_req)
            grant_dma = 1'b1;
      end
   end

   ajcrisc_starve_cnt #(.LIM(STARVE_LIM)) u_starve (
      .clk    (clk),
      .rst    (rst),
      .inc    (grant_cpu && dma_req),
      .clr    (grant_dma),
      .at_lim (at_lim)
   );

   // Memory read data lands in DONE, so a plain copy lines up with the ack.
   assign cpu_rdata = mem_rdata;
   assign dma_rdata = mem_rdata;
   assign busy      = (state != S_IDLE);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= S_IDLE;
         owner     <= OWN_NONE;
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         cpu_ack   <= 1'b0;
         dma_ack   <= 1'b0;
      end else begin
         cpu_ack <= 1'b0;
         dma_ack <= 1'b0;
         case (state)
            S_IDLE: begin
               if (grant_cpu || grant_dma) begin
                  mem_addr  <= grant_dma ? dma_addr : cpu_addr;
                  mem_wdata <= grant_dma ? dma_wdata : cpu_wdata;
                  mem_we    <= ((grant_dma ? dma_rw : cpu_rw) == RW_WRITE);
                  owner     <= owner_code(grant_dma);
                  state     <= S_ISSUE;
               end
            end
            S_ISSUE: begin
               mem_we  <= 1'b0;
               cpu_ack <= (owner == OWN_CPU);
               dma_ack <= (owner == OWN_DMA);
               state   <= S_DONE;
            end
            S_DONE: begin
               owner <= OWN_NONE;
               state <= S_IDLE;
            end
            default: begin
               mem_we <= 1'b0;
               owner  <= OWN_NONE;
               state  <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_ajcrisc_mem_arb.sv
// Bench for ajcrisc_mem_arb: directed scenarios plus a randomized two-requester run
// scored against a transaction-level arbitration and memory model.
module tb_ajcrisc_mem_arb;
   import ajcrisc_pkg::*;

   localparam int AW  = 8;
   localparam int DW  = 8;
   localparam int LIM = 3;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          cpu_req = 1'b0, cpu_rw = 1'b0;
   logic [AW-1:0] cpu_addr = '0;
   logic [DW-1:0] cpu_wdata = '0;
   logic          dma_req = 1'b0, dma_rw = 1'b0;
   logic [AW-1:0] dma_addr = '0;
   logic [DW-1:0] dma_wdata = '0;
   logic [DW-1:0] cpu_rdata, dma_rdata, mem_wdata, mem_rdata;
   logic          cpu_ack, dma_ack, mem_we, busy;
   logic [AW-1:0] mem_addr;
   logic [1:0]    owner;

   logic          pre_we = 1'b0;
   logic [AW-1:0] pre_addr = '0;
   logic [DW-1:0] pre_data = '0;
   logic [DW-1:0] mem     [0:255];
   logic [DW-1:0] ref_mem [0:255];

   int checks = 0;
   int passed = 0;

   ajcrisc_mem_arb #(.AW(AW), .DW(DW), .STARVE_LIM(LIM)) dut (
      .clk(clk), .rst(rst),
      .cpu_req(cpu_req), .cpu_rw(cpu_rw), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
      .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack),
      .dma_req(dma_req), .dma_rw(dma_rw), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
      .dma_rdata(dma_rdata), .dma_ack(dma_ack),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_rdata(mem_rdata),
      .owner(owner), .busy(busy)
   );

   always #5 clk = ~clk;

   // Synchronous single-port memory, 1-cycle read latency; pre_* loads initial contents.
   always @(posedge clk) begin
      if (pre_we)
         mem[pre_addr] <= pre_data;
      else if (mem_we)
         mem[mem_addr] <= mem_wdata;
      mem_rdata <= mem[mem_addr];
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic preload;
      for (int i = 0; i < 256; i++) begin
         pre_we   = 1'b1;
         pre_addr = AW'(i);
         pre_data = (i == 8'h3C) ? 8'hA5 : DW'((i * 37 + 11) & 255);
         ref_mem[i] = pre_data;
         tick();
      end
      pre_we = 1'b0;
      tick();
   endtask

   task automatic test_reset;
      checks++;
      if ({owner, busy, mem_we, mem_addr, mem_wdata, cpu_ack, dma_ack} !== '0)
         $display("FAIL reset_state: got owner=%b busy=%b we=%b addr=%h wdata=%h acks=%b%b expected all 0",
                  owner, busy, mem_we, mem_addr, mem_wdata, cpu_ack, dma_ack);
      else passed++;
      rst = 1'b0;
      tick();
      cpu_req = 1'b1; cpu_rw = RW_WRITE; cpu_addr = 8'h10; cpu_wdata = 8'h77;
      tick();
      checks++;
      if (mem_we !== 1'b1) $display("FAIL reset_pre_issue_we: got %b expected 1", mem_we);
      else passed++;
      rst = 1'b1;
      #1;
      checks++;
      if ({mem_we, owner, busy, cpu_ack} !== 5'b0)
         $display("FAIL reset_async: got we=%b owner=%b busy=%b ack=%b expected 0", mem_we, owner, busy, cpu_ack);
      else passed++;
      tick();
      checks++;
      if (cpu_ack !== 1'b0) $display("FAIL reset_no_ack: got %b expected 0", cpu_ack);
      else passed++;
      cpu_req = 1'b0;
      rst = 1'b0;
      for (int i = 0; i < 10; i++) begin
         tick();
         checks++;
         if ({owner, busy, mem_we, mem_addr, mem_wdata, cpu_ack, dma_ack} !== '0)
            $display("FAIL reset_idle_%0d: got owner=%b busy=%b we=%b addr=%h acks=%b%b expected all 0",
                     i, owner, busy, mem_we, mem_addr, cpu_ack, dma_ack);
         else passed++;
      end
   endtask

   task automatic test_cpu_read;
      cpu_req = 1'b1; cpu_rw = RW_READ; cpu_addr = 8'h3C;
      tick();
      checks++;
      if (mem_addr !== 8'h3C || owner !== OWN_CPU || busy !== 1'b1 || mem_we !== 1'b0 || cpu_ack !== 1'b0)
         $display("FAIL cpu_read_issue: got addr=%h owner=%b busy=%b we=%b ack=%b expected 3c 01 1 0 0",
                  mem_addr, owner, busy, mem_we, cpu_ack);
      else passed++;
      tick();
      checks++;
      if (cpu_ack !== 1'b1 || cpu_rdata !== 8'hA5 || dma_ack !== 1'b0 || mem_we !== 1'b0)
         $display("FAIL cpu_read_done: got ack=%b rdata=%h dma_ack=%b we=%b expected 1 a5 0 0",
                  cpu_ack, cpu_rdata, dma_ack, mem_we);
      else passed++;
      cpu_req = 1'b0;
      tick();
      checks++;
      if (cpu_ack !== 1'b0 || owner !== OWN_NONE || busy !== 1'b0)
         $display("FAIL cpu_read_after: got ack=%b owner=%b busy=%b expected 0 00 0", cpu_ack, owner, busy);
      else passed++;
   endtask

   task automatic test_dma_write;
      dma_req = 1'b1; dma_rw = RW_WRITE; dma_addr = 8'h80; dma_wdata = 8'h5A;
      tick();
      checks++;
      if (mem_we !== 1'b1 || mem_addr !== 8'h80 || mem_wdata !== 8'h5A || owner !== OWN_DMA || dma_ack !== 1'b0)
         $display("FAIL dma_write_issue: got we=%b addr=%h wdata=%h owner=%b ack=%b expected 1 80 5a 10 0",
                  mem_we, mem_addr, mem_wdata, owner, dma_ack);
      else passed++;
      tick();
      checks++;
      if (mem_we !== 1'b0 || dma_ack !== 1'b1 || cpu_ack !== 1'b0)
         $display("FAIL dma_write_done: got we=%b dma_ack=%b cpu_ack=%b expected 0 1 0", mem_we, dma_ack, cpu_ack);
      else passed++;
      ref_mem[8'h80] = 8'h5A;
      dma_req = 1'b0;
      tick();
      cpu_req = 1'b1; cpu_rw = RW_READ; cpu_addr = 8'h80;
      tick();
      tick();
      checks++;
      if (cpu_ack !== 1'b1 || cpu_rdata !== 8'h5A)
         $display("FAIL dma_write_readback: got ack=%b rdata=%h expected 1 5a", cpu_ack, cpu_rdata);
      else passed++;
      cpu_req = 1'b0;
      tick();
   endtask

   task automatic test_simultaneous;
      cpu_req = 1'b1; cpu_rw = RW_READ; cpu_addr = 8'h01;
      dma_req = 1'b1; dma_rw = RW_READ; dma_addr = 8'h02;
      tick();
      checks++;
      if (owner !== OWN_CPU || mem_addr !== 8'h01)
         $display("FAIL simul_first_grant: got owner=%b addr=%h expected 01 01", owner, mem_addr);
      else passed++;
      tick();
      checks++;
      if (cpu_ack !== 1'b1 || dma_ack !== 1'b0 || cpu_rdata !== ref_mem[1])
         $display("FAIL simul_cpu_ack: got acks=%b%b rdata=%h expected 10 %h", cpu_ack, dma_ack, cpu_rdata, ref_mem[1]);
      else passed++;
      cpu_req = 1'b0;
      tick();
      tick();
      checks++;
      if (owner !== OWN_DMA || mem_addr !== 8'h02)
         $display("FAIL simul_dma_grant: got owner=%b addr=%h expected 10 02", owner, mem_addr);
      else passed++;
      tick();
      checks++;
      if (dma_ack !== 1'b1 || cpu_ack !== 1'b0 || dma_rdata !== ref_mem[2])
         $display("FAIL simul_dma_ack: got acks=%b%b rdata=%h expected 01 %h", cpu_ack, dma_ack, dma_rdata, ref_mem[2]);
      else passed++;
      dma_req = 1'b0;
      tick();
   endtask

   task automatic test_starvation;
      logic [1:0] exp_own;
      cpu_req = 1'b1; cpu_rw = RW_READ; cpu_addr = 8'h04;
      dma_req = 1'b1; dma_rw = RW_READ; dma_addr = 8'h05;
      for (int k = 0; k < 8; k++) begin
         exp_own = ((k % 4) == 3) ? OWN_DMA : OWN_CPU;
         tick();
         checks++;
         if (owner !== exp_own)
            $display("FAIL starve_grant_%0d: got owner=%b expected %b", k, owner, exp_own);
         else passed++;
         tick();
         checks++;
         if (cpu_ack !== (exp_own == OWN_CPU) || dma_ack !== (exp_own == OWN_DMA))
            $display("FAIL starve_ack_%0d: got acks=%b%b expected owner %b", k, cpu_ack, dma_ack, exp_own);
         else passed++;
         tick();
      end
      cpu_req = 1'b0;
      dma_req = 1'b0;
      tick();
   endtask

   task automatic test_back_to_back;
      cpu_req = 1'b1; cpu_rw = RW_READ; cpu_addr = 8'h00;
      for (int i = 0; i < 3; i++) begin
         tick();
         checks++;
         if (mem_addr !== AW'(i) || owner !== OWN_CPU || cpu_ack !== 1'b0)
            $display("FAIL b2b_issue_%0d: got addr=%h owner=%b ack=%b expected %h 01 0", i, mem_addr, owner, cpu_ack, i);
         else passed++;
         tick();
         checks++;
         if (cpu_ack !== 1'b1 || cpu_rdata !== ref_mem[i])
            $display("FAIL b2b_ack_%0d: got ack=%b rdata=%h expected 1 %h", i, cpu_ack, cpu_rdata, ref_mem[i]);
         else passed++;
         if (i == 2) cpu_req = 1'b0;
         else cpu_addr = AW'(i + 1);
         tick();
         checks++;
         if (cpu_ack !== 1'b0 || busy !== 1'b0)
            $display("FAIL b2b_idle_%0d: got ack=%b busy=%b expected 0 0", i, cpu_ack, busy);
         else passed++;
      end
      tick();
      checks++;
      if (busy !== 1'b0 || owner !== OWN_NONE)
         $display("FAIL b2b_no_extra: got busy=%b owner=%b expected 0 00", busy, owner);
      else passed++;
   endtask

   // Transaction-level model: one access at a time, each owning the bus for the three
   // cycles starting at its arbitration cycle; DMA takes a contested slot once CPU has
   // beaten it LIM times in a row.
   task automatic test_random;
      int            next_arb, ack_c, win, cpu_wins;
      logic          exp_we;
      logic [AW-1:0] exp_addr;
      logic [DW-1:0] exp_wd, exp_rd, rd;
      next_arb = 0; ack_c = -10; win = 0; cpu_wins = 0;
      exp_we = 1'b0; exp_addr = '0; exp_wd = '0; exp_rd = '0;
      for (int c = 0; c < 1500; c++) begin
         if (c == ack_c - 1) begin
            checks++;
            if (owner !== (win == 2 ? OWN_DMA : OWN_CPU) || mem_addr !== exp_addr || mem_we !== exp_we ||
                (exp_we && mem_wdata !== exp_wd))
               $display("FAIL rand_issue_c%0d: got owner=%b addr=%h we=%b wdata=%h expected win=%0d %h %b %h",
                        c, owner, mem_addr, mem_we, mem_wdata, win, exp_addr, exp_we, exp_wd);
            else passed++;
         end
         checks++;
         if (cpu_ack !== (c == ack_c && win == 1) || dma_ack !== (c == ack_c && win == 2))
            $display("FAIL rand_ack_c%0d: got acks=%b%b expected win=%0d at cycle %0d", c, cpu_ack, dma_ack, win, ack_c);
         else passed++;
         if (c == ack_c) begin
            if (!exp_we) begin
               rd = (win == 1) ? cpu_rdata : dma_rdata;
               checks++;
               if (rd !== exp_rd)
                  $display("FAIL rand_rdata_c%0d: got %h expected %h addr %h", c, rd, exp_rd, exp_addr);
               else passed++;
            end
            if (win == 1) cpu_req = 1'b0;
            else dma_req = 1'b0;
         end
         if (!cpu_req && c < 1450 && $urandom_range(0, 3) != 0) begin
            cpu_req = 1'b1; cpu_rw = 1'($urandom_range(0, 1));
            cpu_addr = AW'($urandom_range(32, 63)); cpu_wdata = DW'($urandom);
         end
         if (!dma_req && c < 1450 && $urandom_range(0, 2) != 0) begin
            dma_req = 1'b1; dma_rw = 1'($urandom_range(0, 1));
            dma_addr = AW'($urandom_range(32, 63)); dma_wdata = DW'($urandom);
         end
         if (c >= next_arb && (cpu_req || dma_req)) begin
            if (cpu_req && dma_req) win = (cpu_wins >= LIM) ? 2 : 1;
            else win = cpu_req ? 1 : 2;
            if (win == 2) cpu_wins = 0;
            else if (dma_req && cpu_wins < LIM) cpu_wins++;
            exp_addr = (win == 1) ? cpu_addr : dma_addr;
            exp_we   = (win == 1) ? cpu_rw : dma_rw;
            exp_wd   = (win == 1) ? cpu_wdata : dma_wdata;
            exp_rd   = ref_mem[exp_addr];
            if (exp_we) ref_mem[exp_addr] = exp_wd;
            ack_c    = c + 2;
            next_arb = c + 3;
         end
         tick();
      end
      checks++;
      if (cpu_req !== 1'b0 || dma_req !== 1'b0 || busy !== 1'b0)
         $display("FAIL rand_drain: got cpu_req=%b dma_req=%b busy=%b expected all served", cpu_req, dma_req, busy);
      else passed++;
   endtask

   initial begin
      preload();
      test_reset();
      test_cpu_read();
      test_dma_write();
      test_simultaneous();
      test_starvation();
      test_back_to_back();
      test_random();
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
